// File: rtl/mux_select_arbiter_pkg.sv
// mux_select_arbiter_pkg: shared arbiter state encoding and width helper.
package mux_select_arbiter_pkg;
  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux_select_arbiter_rr_priority_pick.sv
// rr_priority_pick: first available requester searching from start, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  input  logic [N-1:0] excl_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  logic [N-1:0] avail;
  assign avail = req_i & ~excl_i;
  always_comb begin
    int k;
    onehot_o = '0;
    idx_o = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start_i) + i) % N;
      if (!found_o && avail[k]) begin
        found_o = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o = W'(k);
      end
    end
  end
endmodule

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin one-hot grant generator with optional forced rotation.
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int INPUTS = 2,
  parameter int MAX_HOLD = 0,
  localparam int INDEX_WIDTH = (clog2(INPUTS) < 1) ? 1 : clog2(INPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUTS-1:0]      request,
  output logic [INPUTS-1:0]      grant,
  output logic                   grantValid,
  output logic [INDEX_WIDTH-1:0] grantIndex
);
  localparam int CW = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(INPUTS - 1);

  arb_state_e state_q, state_d;
  logic [INPUTS-1:0] grant_q, grant_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d, next_q, next_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INPUTS-1:0] win_oh;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic win_found, released, rotate, rearb;

  // Excluding grant_q removes the current owner; it is all-zero while idle.
  rr_priority_pick #(.N(INPUTS), .W(INDEX_WIDTH)) u_pick (
    .req_i   (request),
    .start_i (next_q),
    .excl_i  (grant_q),
    .onehot_o(win_oh),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign released = ~|(request & grant_q);
  assign rotate = (MAX_HOLD != 0) && (cnt_q == HOLD_LIMIT) && win_found;
  assign rearb = (state_q == ARB_IDLE) ? win_found : (released || rotate);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    next_d = next_q;
    cnt_d = cnt_q;
    if (rearb) begin
      state_d = win_found ? ARB_GRANTED : ARB_IDLE;
      grant_d = win_oh;
      idx_d = win_idx;
      next_d = win_found ? ((win_idx == LAST) ? '0 : win_idx + 1'b1) : next_q;
      cnt_d = win_found ? CW'(1) : '0;
    end else if (state_q == ARB_GRANTED && MAX_HOLD != 0 && cnt_q != HOLD_LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q <= '0;
      next_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      next_q <= next_d;
      cnt_q <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign grantValid = state_q == ARB_GRANTED;
  assign grantIndex = idx_q;
endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Round-robin arbiter that generates the registered one-hot `select` vector and `outputEnable` consumed by the codebase's one-hot priority multiplexer. Requesters raise `request[i]`; the arbiter grants exactly one at a time, holds the grant until the owner releases it, and optionally forces rotation after a bounded hold time. It sits in front of every shared mux, for example shared bus or peripheral ports, so the mux never sees more than one select bit set.

## Interface
- `INPUTS`, 2: number of requesters; legal range 1..8, matching the mux widths.
- `MAX_HOLD`, 0: maximum consecutive cycles one owner may hold the grant while others wait; 0 disables forced rotation.
- `INDEX_WIDTH`, derived: `max(1, clog2(INPUTS))`; local, not overridable.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active-high.
- `request`  in  INPUTS  level request per requester.
- `grant`  out  INPUTS  registered one-hot grant; drives mux `select`.
- `grantValid`  out  1  registered; equals `|grant`.
- `grantIndex`  out  INDEX_WIDTH  registered binary index of the current owner; 0 when idle.

## Operation
- States: `IDLE` (no grant) and `GRANTED` (one owner).
- Pointer `next`: the highest-priority index for the next arbitration. Search order is `next`, `next+1`, … wrapping modulo INPUTS.
- `IDLE`:
  - If any `request` is high, grant the first requester in search order.
  - Go to `GRANTED` and set `next = owner+1` (wraps INPUTS-1 → 0).
- `GRANTED`:
  - Owner keeps the grant while `request[owner]` is high and no forced rotation is due.
- Release (sampled `request[owner]` low): arbitrate among the remaining requests, owner excluded.
  - If a winner exists, the grant moves directly to it with no idle cycle.
  - Otherwise go to `IDLE`, with grant cleared.
- Hold counter:
  - Counts cycles in `GRANTED` for the current owner and resets on every new grant.
  - When `MAX_HOLD != 0`, count reaches `MAX_HOLD`, and another request is pending, the grant rotates as on release.
  - If no other request is pending, the counter saturates and the owner keeps the grant.
- Invariant: `grant` is zero or one-hot every cycle. `grantIndex` matches `grant`.
- `INPUTS == 1`:
  - Grant follows the request with one cycle of latency.
  - Rotation never triggers because no other requester exists.

## Timing
- Reset (edge with `rst` high):
  - `grant = 0`, `grantValid = 0`, `grantIndex = 0`.
  - State `IDLE`, `next = 0`, hold counter 0.
  - Reset mid-grant clears everything at that edge.
- Grant latency: request sampled at edge n, grant visible after edge n+1; one cycle.
- Release latency: owner drops request before edge n, new grant or idle after edge n.
- If a request drops in the same cycle the grant is issued, the grant still appears for one cycle, then releases. Requesters must tolerate this.
- If the previous owner re-requests in the same cycle as a waiting requester, the waiting requester wins, because the pointer has already advanced past the owner.
- Forced rotation happens at the edge where count equals `MAX_HOLD`. The owner has then held the grant for exactly `MAX_HOLD` cycles.

## Structure
- The shared utility package holds:
  - the state encoding constants `ARB_IDLE` and `ARB_GRANTED`;
  - a `clog2` helper function used for `INDEX_WIDTH`.
- One combinational sub-module, `rr_priority_pick`:
  - inputs: request vector, start pointer, exclude mask;
  - outputs: one-hot winner, binary index, found flag.
- The top level holds the state register, pointer, hold counter and output registers.

## Test plan
- Reset, then `request=0b01` with INPUTS=2 → `grant=0b01`, `grantIndex=0`, `grantValid=1` one cycle later; drop request → `grant=0` next cycle.
- INPUTS=4, `request=0b1111` held, each owner drops its request for one cycle after being granted → grant order 0,1,2,3,0 with no idle cycles between owners.
- INPUTS=3, owner 2 granted, `request=0b101` → on release the pointer wraps, so `grant=0b001`.
- `MAX_HOLD=4`, INPUTS=2, `request=0b11` held continuously → grant alternates 0b01 and 0b10 every 4 cycles. With `request=0b01` only, the grant stays 0b01 indefinitely.
- `rst` asserted while `grant=0b100` → after that edge all outputs are 0. With `request=0b111` held, the first post-reset grant is 0b001.
- Random requests for 10k cycles → scoreboard checks:
  - `grant` is one-hot or zero;
  - `grantIndex` matches `grant`;
  - no requester waits more than `(INPUTS-1)*MAX_HOLD+INPUTS` cycles.
